// File: rtl/pwm_fader.sv
// Multi-channel PWM generator with per-channel OFF/ON/BLINK/BREATHE effects on a shared counter.
// Duty updates only at period wrap (glitch-free); writes accepted every cycle, no backpressure.
module pwm_fader #(
  parameter int CHANNELS  = 3,
  parameter int BITS      = 8,
  parameter int PRESCALER = 0,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic [1:0]          wr_mode,
  input  logic [BITS-1:0]     wr_level,
  output logic [CHANNELS-1:0] pwm,
  output logic                period_start
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  localparam logic [CH_W:0] CH_LIMIT = CHANNELS[CH_W:0];

  logic [BITS-1:0] cnt;
  logic            wrap;
  logic            tick;
  logic            wr_valid;

  mode_e           mode_q  [CHANNELS];
  logic [BITS-1:0] level_q [CHANNELS];
  logic [BITS-1:0] duty_q  [CHANNELS];
  logic [BITS-1:0] ramp_q  [CHANNELS];
  logic            dir_q   [CHANNELS];
  logic            phase_q [CHANNELS];

  assign wrap     = (cnt == {BITS{1'b1}});
  assign wr_valid = wr_en && ({1'b0, wr_ch} < CH_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  generate
    if (PRESCALER == 0) begin : g_no_pre
      assign tick = wrap;
    end else begin : g_pre
      logic [PRESCALER-1:0] pre_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pre_q <= '0;
        end else if (wrap) begin
          pre_q <= pre_q + 1'b1;
        end
      end
      assign tick = wrap && (pre_q == {PRESCALER{1'b1}});
    end
  endgenerate

  // Later assignments win: a write overrides the tick update on its channel,
  // while duty_q always samples the pre-write state on a wrap cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        mode_q[i]  <= MODE_OFF;
        level_q[i] <= '0;
        duty_q[i]  <= '0;
        ramp_q[i]  <= '0;
        dir_q[i]   <= 1'b0;
        phase_q[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (wrap) begin
          case (mode_q[i])
            MODE_ON:      duty_q[i] <= level_q[i];
            MODE_BLINK:   duty_q[i] <= phase_q[i] ? level_q[i] : '0;
            MODE_BREATHE: duty_q[i] <= ramp_q[i];
            default:      duty_q[i] <= '0;
          endcase
        end

        if (tick) begin
          if (mode_q[i] == MODE_BLINK) begin
            phase_q[i] <= ~phase_q[i];
          end else if (mode_q[i] == MODE_BREATHE) begin
            if (level_q[i] == '0) begin
              ramp_q[i] <= '0;
              dir_q[i]  <= 1'b0;
            end else if (!dir_q[i]) begin
              if (ramp_q[i] < level_q[i]) begin
                ramp_q[i] <= ramp_q[i] + 1'b1;
              end else begin
                dir_q[i]  <= 1'b1;
                ramp_q[i] <= ramp_q[i] - 1'b1;
              end
            end else begin
              if (ramp_q[i] > '0) begin
                ramp_q[i] <= ramp_q[i] - 1'b1;
              end else begin
                dir_q[i]  <= 1'b0;
                ramp_q[i] <= ramp_q[i] + 1'b1;
              end
            end
          end
        end

        if (wr_valid && (wr_ch == CH_W'(i))) begin
          mode_q[i]  <= mode_e'(wr_mode);
          level_q[i] <= wr_level;
          ramp_q[i]  <= '0;
          dir_q[i]   <= 1'b0;
          phase_q[i] <= 1'b1;
        end
      end
    end
  end

  // Gated by rst_n so outputs drop in the same cycle reset is asserted.
  always_comb begin
    pwm = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      pwm[i] = rst_n && (cnt < duty_q[i]);
    end
  end

  assign period_start = rst_n && (cnt == '0);

endmodule

// File: tb/tb_pwm_fader.sv
// Directed bench for pwm_fader: measures per-period duty of each channel against hand-computed values.
module tb_pwm_fader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_ch = '0;
  logic [1:0] wr_mode = '0;
  logic [7:0] wr_level = '0;
  logic [2:0] pwm_a, pwm_b;
  logic       ps_a, ps_b;

  int errors = 0;
  int checks = 0;
  int bad_shape = 0;
  int duty_a[3];
  int duty_b[3];

  int exp_a[8]  = '{0, 1, 2, 3, 2, 1, 0, 1};
  int exp_b[19] = '{0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 2, 2, 2, 2};

  pwm_fader #(.CHANNELS(3), .BITS(8), .PRESCALER(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_ch(wr_ch), .wr_mode(wr_mode),
    .wr_level(wr_level), .pwm(pwm_a), .period_start(ps_a)
  );

  pwm_fader #(.CHANNELS(3), .BITS(8), .PRESCALER(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_ch(wr_ch), .wr_mode(wr_mode),
    .wr_level(wr_level), .pwm(pwm_b), .period_start(ps_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wr(input int ch, input int mode, input int level);
    wr_en    = 1'b1;
    wr_ch    = 2'(ch);
    wr_mode  = 2'(mode);
    wr_level = 8'(level);
    @(negedge clk);
    wr_en    = 1'b0;
  endtask

  // Syncs to the next cnt==0 and counts high cycles over one full period.
  task automatic measure();
    int n = 0;
    bit seen_low[3];
    while (!ps_a && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!ps_a) chk("sync_timeout", 0, 1);
    for (int c = 0; c < 3; c++) begin
      duty_a[c]   = 0;
      duty_b[c]   = 0;
      seen_low[c] = 1'b0;
    end
    repeat (256) begin
      for (int c = 0; c < 3; c++) begin
        if (pwm_a[c]) begin
          duty_a[c]++;
          if (seen_low[c]) bad_shape++;
        end else begin
          seen_low[c] = 1'b1;
        end
        if (pwm_b[c]) duty_b[c]++;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int mid;

    #23;
    chk("rst_pwm", int'(pwm_a), 0);
    chk("rst_ps", int'(ps_a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ps_after_release", int'(ps_a), 1);
    @(negedge clk);
    chk("ps_cnt1", int'(ps_a), 0);

    // ch0 ON 64
    wr(0, 1, 64);
    measure();
    chk("on64_ch0", duty_a[0], 64);
    chk("on64_ch1", duty_a[1], 0);
    chk("on64_ch2", duty_a[2], 0);
    measure();
    chk("on64_ch0_rep", duty_a[0], 64);

    // ch1 ON 255 then 0
    wr(1, 1, 255);
    measure();
    chk("on255_ch1", duty_a[1], 255);
    chk("on255_ch0", duty_a[0], 64);
    wr(1, 1, 0);
    measure();
    chk("on0_ch1", duty_a[1], 0);

    // ch2 BLINK 128
    wr(2, 2, 128);
    for (int p = 0; p < 4; p++) begin
      measure();
      chk($sformatf("blink_p%0d", p), duty_a[2], (p % 2 == 0) ? 128 : 0);
    end

    // out-of-range channel write is ignored
    wr(3, 1, 255);
    measure();
    chk("badch_ch0", duty_a[0], 64);
    chk("badch_ch1", duty_a[1], 0);
    chk("badch_ch2", duty_a[2], 0);

    // mid-period write at cnt=100 does not disturb current period
    mid = 0;
    for (int k = 0; k < 256; k++) begin
      if (pwm_a[0]) mid++;
      if (k == 100) begin
        wr_en = 1'b1; wr_ch = 2'd0; wr_mode = 2'd1; wr_level = 8'd200;
      end else begin
        wr_en = 1'b0;
      end
      @(negedge clk);
    end
    chk("midwr_cur", mid, 64);
    measure();
    chk("midwr_next", duty_a[0], 200);

    // asynchronous reset mid-period
    repeat (30) @(negedge clk);
    chk("pre_rst_pwm0", int'(pwm_a[0]), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_pwm", int'(pwm_a), 0);
    chk("async_rst_ps", int'(ps_a), 0);
    chk("async_rst_pwm_b", int'(pwm_b), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_ps_a", int'(ps_a), 1);
    chk("rel_ps_b", int'(ps_b), 1);
    measure();
    chk("rel_off_ch0", duty_a[0], 0);
    chk("rel_off_ch1", duty_a[1], 0);
    chk("rel_off_ch2", duty_a[2], 0);

    // ch0 BREATHE 3 on both prescaler settings
    wr(0, 3, 3);
    for (int p = 0; p < 19; p++) begin
      measure();
      if (p < 8) chk($sformatf("breathe_a_p%0d", p), duty_a[0], exp_a[p]);
      chk($sformatf("breathe_b_p%0d", p), duty_b[0], exp_b[p]);
    end

    // write landing exactly on the wrap cycle
    repeat (255) @(negedge clk);
    wr(1, 1, 100);
    measure();
    chk("wrapwr_cur", duty_a[1], 0);
    measure();
    chk("wrapwr_next", duty_a[1], 100);

    chk("pwm_shape", bad_shape, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
